bsg_fifo_2el_rr_ctrl: RTL
=========================

Name: bsg_fifo_2el_rr_ctrl

Overview:
- Two-entry, two-producer/one-consumer FIFO built around a 2-element 1r1w synthesized storage array.
- Contains a round-robin arbiter, read/write pointer sequencing, and occupancy tracking.
- Generates the storage write-enable, write address and read address, and guarantees the read and write addresses never collide while the output is valid.
- Sits between two upstream request sources and a single downstream consumer in the same clock domain.

Parameters:
- width_p, 36, payload width per entry.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  reset, synchronous, active-low.
- v_i  in  2  producer valid; bit i belongs to producer i.
- data_i  in  2*width_p  producer payloads; producer i occupies [i*width_p +: width_p].
- ready_o  out  2  producer i's data is accepted this cycle when v_i[i] & ready_o[i].
- v_o  out  1  head entry valid.
- data_o  out  width_p  head entry payload.
- yumi_i  in  1  consumer dequeues the head this cycle; legal only when v_o=1.
- count_o  out  2  occupancy, 0..2.

Behaviour:
- State:
  - wptr (1b), rptr (1b), count (2b), last_grant (1b).
  - Storage array: 2 x width_p, 1r1w, synchronous write, combinational read.
- Reset (reset_n_i=0 at a clock edge):
  - wptr=0, rptr=0, count=0, last_grant=1.
  - Stored data is discarded, not cleared.
  - While reset_n_i=0: ready_o=2'b00, v_o=0, count_o=0.
  - Reset asserted mid-operation drops all entries; no enqueue or dequeue takes effect on that edge.
- Arbitration (combinational):
  - Only one valid: that producer is granted.
  - Both valid: grant goes to producer ~last_grant.
  - ready_o[i] = reset_n_i & (count!=2) & grant[i].
  - At most one ready_o bit is ever high.
  - last_grant updates to the accepted producer index only on a successful enqueue.
  - Producers must hold v_i and data stable until accepted.
- Enqueue (enq = |(v_i & ready_o)):
  - Write the granted payload to mem[wptr]; wptr flips.
- Dequeue (deq = yumi_i & v_o):
  - rptr flips.
  - yumi_i while v_o=0 is ignored; no state change.
- Count update:
  - count += enq - deq.
  - enq and deq in the same cycle are legal only when count=1; count stays 1.
  - Full (count=2) blocks enqueue even if yumi_i=1. No full-throughput pass-through; this preserves the no read/write same-address rule.
- Outputs:
  - v_o = (count!=0).
  - data_o = mem[rptr] (combinational).
  - count_o = count.
- Latency: data accepted at edge t is visible on data_o/v_o after edge t; no same-cycle bypass from input to output.
- Address safety:
  - When count=1 the write slot is wptr and the read slot is rptr, which differ.
  - When count=0, data_o is don't-care (v_o=0).
- Ordering:
  - Strict FIFO across both producers, in acceptance order.
  - Each producer is guaranteed a grant within 2 enqueues once valid.

Optional Feature:
- Macro BSG_FIFO_RR_STATS_EN.
- Defined:
  - Adds output enq_cnt_o (2x16, producer i at [i*16 +: 16]).
  - Each counter counts that producer's accepted enqueues, saturates at 16'hFFFF, and is cleared by reset.
- Undefined:
  - Port and counters are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package bsg_fifo_2el_pkg:
  - localparam els_lp=2.
  - Producer-index typedef (1b).
  - Occupancy typedef (2b).
  - Counter width constant 16.
- One natural sub-module: bsg_rr_arb_2, a 2-input round-robin arbiter.
  - Inputs: reqs, last_grant, ack-update.
  - Output: one-hot grant.
- Storage is instantiated as the team's 1r1w synth memory with width_p and els 2, read/write same address disallowed.

Test Plan:
- Reset then single push: v_i=01, data0=36'hA5A5A5A5A after reset release.
  - ready_o=01, and one edge later v_o=1, data_o=36'hA5A5A5A5A, count_o=1.
- Both producers continuously valid (data0=1, data1=2), consumer idle.
  - Accept order is producer 0 then producer 1; count_o reaches 2 and ready_o=00 afterwards.
  - Pop order returns 1 then 2.
- count=1 with simultaneous enq and yumi_i.
  - count_o stays 1; the next data_o is the newly written value.
  - Storage read and write addresses differ in that cycle (assert).
- Full FIFO with yumi_i=1 and v_i=11.
  - ready_o=00 that cycle; the next cycle count_o=1 and ready_o is asserted for the producer with priority.
- yumi_i=1 while empty.
  - No pointer or count change; v_o stays 0.
- reset_n_i low while count=2, then release.
  - v_o=0, count_o=0, ready_o=00 during reset.
  - The first push after release appears at data_o.
  - With BSG_FIFO_RR_STATS_EN defined, enq_cnt_o reads 0 after reset.

Source files
------------

// File: rtl/bsg_fifo_2el_pkg.sv
// rtl/bsg_fifo_2el_pkg.sv - shared types and constants for the two-producer 2-entry FIFO
package bsg_fifo_2el_pkg;

    localparam int els_lp       = 2;
    localparam int cnt_width_lp = 16;

    typedef logic       prod_idx_t;
    typedef logic [1:0] occ_t;

    localparam occ_t occ_full_lp = 2'd2;

endpackage

// File: rtl/bsg_mem_1r1w_synth.sv
// rtl/bsg_mem_1r1w_synth.sv - 1r1w storage array, synchronous write, combinational read
module bsg_mem_1r1w_synth #(
    parameter int width_p                = 36,
    parameter int els_p                  = 2,
    parameter bit read_write_same_addr_p = 1'b0,
    parameter int addr_width_lp          = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic                     r_v_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] r_mem [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            r_mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = r_v_i ? r_mem[r_addr_i] : '0;

    if (!read_write_same_addr_p) begin : g_addr_chk
        always_ff @(posedge w_clk_i) begin
            if (w_v_i && r_v_i) begin
                assert (w_addr_i != r_addr_i);
            end
        end
    end

endmodule

// File: rtl/bsg_rr_arb_2.sv
// rtl/bsg_rr_arb_2.sv - two-input round-robin arbiter; grant is one-hot, state kept by the caller
module bsg_rr_arb_2
    import bsg_fifo_2el_pkg::*;
(
    input  logic [1:0] reqs_i,
    input  prod_idx_t  last_grant_i,
    input  logic       ack_i,
    output logic [1:0] grant_o,
    output prod_idx_t  last_grant_next_o
);

    logic [1:0] w_grant;

    // On contention the producer that did not win last time goes first
    always_comb begin
        w_grant = 2'b00;
        case (reqs_i)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = last_grant_i ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign grant_o           = w_grant;
    assign last_grant_next_o = ack_i ? w_grant[1] : last_grant_i;

endmodule

// File: rtl/bsg_fifo_2el_rr_ctrl.sv
// rtl/bsg_fifo_2el_rr_ctrl.sv - 2-entry FIFO, two round-robin producers, one consumer; BSG_FIFO_RR_STATS_EN adds enq_cnt_o
module bsg_fifo_2el_rr_ctrl
    import bsg_fifo_2el_pkg::*;
#(
    parameter int width_p = 36
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [1:0]           v_i,
    input  logic [2*width_p-1:0] data_i,
    output logic [1:0]           ready_o,
    output logic                 v_o,
    output logic [width_p-1:0]   data_o,
    input  logic                 yumi_i,
    output occ_t                 count_o
`ifdef BSG_FIFO_RR_STATS_EN
    ,
    output logic [2*cnt_width_lp-1:0] enq_cnt_o
`endif
);

    logic      r_wptr;
    logic      r_rptr;
    occ_t      r_count;
    prod_idx_t r_last_grant;

    logic [1:0]         w_grant;
    logic [1:0]         w_ready;
    logic               w_enq;
    logic               w_deq;
    logic               w_v;
    prod_idx_t          w_last_grant_next;
    logic [width_p-1:0] w_enq_data;

    bsg_rr_arb_2 u_arb (
        .reqs_i            (v_i),
        .last_grant_i      (r_last_grant),
        .ack_i             (w_enq),
        .grant_o           (w_grant),
        .last_grant_next_o (w_last_grant_next)
    );

    // Full blocks enqueue even with a concurrent dequeue, so a write never lands on the read slot
    assign w_ready    = {2{reset_n_i & (r_count != occ_full_lp)}} & w_grant;
    assign w_enq      = |(v_i & w_ready);
    assign w_v        = reset_n_i & (r_count != 2'd0);
    assign w_deq      = yumi_i & w_v;
    assign w_enq_data = w_grant[1] ? data_i[2*width_p-1:width_p] : data_i[width_p-1:0];

    bsg_mem_1r1w_synth #(
        .width_p                (width_p),
        .els_p                  (els_lp),
        .read_write_same_addr_p (1'b0)
    ) u_mem (
        .w_clk_i  (clk_i),
        .w_v_i    (w_enq),
        .w_addr_i (r_wptr),
        .w_data_i (w_enq_data),
        .r_v_i    (w_v),
        .r_addr_i (r_rptr),
        .r_data_o (data_o)
    );

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_count      <= 2'd0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_enq) begin
                r_wptr <= ~r_wptr;
            end
            if (w_deq) begin
                r_rptr <= ~r_rptr;
            end
            r_count      <= r_count + occ_t'(w_enq) - occ_t'(w_deq);
            r_last_grant <= w_last_grant_next;
        end
    end

    assign ready_o = w_ready;
    assign v_o     = w_v;
    assign count_o = reset_n_i ? r_count : 2'd0;

`ifdef BSG_FIFO_RR_STATS_EN
    logic [cnt_width_lp-1:0] r_enq_cnt [2];

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_enq_cnt[0] <= '0;
            r_enq_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (v_i[i] && w_ready[i] && (r_enq_cnt[i] != '1)) begin
                    r_enq_cnt[i] <= r_enq_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign enq_cnt_o = {r_enq_cnt[1], r_enq_cnt[0]};
`endif

endmodule
